// File: rtl/ex_muldiv_sequencer_if.sv
// Handshake bundle between the ID/EX pipeline stage and the multiply/divide sequencer.
interface ex_muldiv_sequencer_if #(parameter int XLEN = 32);
   logic            op_valid;
   logic [5:0]      funct;
   logic [XLEN-1:0] rs;
   logic [XLEN-1:0] rt;
   logic            flush;
   logic            busy;
   logic            stall;
   logic            done;
   logic            div_by_zero;
   logic [XLEN-1:0] hilo_data;

   modport master (output op_valid, funct, rs, rt, flush,
                   input  busy, stall, done, div_by_zero, hilo_data);
   modport slave  (input  op_valid, funct, rs, rt, flush,
                   output busy, stall, done, div_by_zero, hilo_data);
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle shift-add multiply / restoring divide sequencer beside the EX-stage ALU.
// Owns HI/LO, serves MFHI/MFLO, and stalls the front of the pipe while busy.
//
// state  | meaning
// S_IDLE | waiting for MULT/MULTU/DIV/DIVU; HI/LO readable
// S_PREP | convert captured operands to magnitudes, record result signs
// S_ITER | one multiply or divide step per cycle, XLEN steps
// S_FIX  | sign-correct, write HI/LO, pulse done next cycle
module ex_muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input logic                  clk,
   input logic                  reset,
   ex_muldiv_sequencer_if.slave bus
);
   localparam int            CW       = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
   localparam logic [5:0]    F_MFHI   = 6'h10;
   localparam logic [5:0]    F_MFLO   = 6'h12;
   localparam logic [5:0]    F_MULT   = 6'h18;
   localparam logic [5:0]    F_MULTU  = 6'h19;
   localparam logic [5:0]    F_DIV    = 6'h1A;
   localparam logic [5:0]    F_DIVU   = 6'h1B;

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              is_div_q, is_div_d;
   logic              is_signed_q, is_signed_d;
   logic [XLEN-1:0]   op_a_q, op_a_d;
   logic [XLEN-1:0]   op_b_q, op_b_d;
   logic [XLEN-1:0]   acc_hi_q, acc_hi_d;
   logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic              neg_q, neg_d;
   logic              rem_neg_q, rem_neg_d;
   logic              dbz_path_q, dbz_path_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic              done_q, done_d;
   logic              dbz_q, dbz_d;

   logic              is_muldiv;
   logic              is_mf;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic [2*XLEN-1:0] prod_fix;

   always_comb begin
      is_muldiv = bus.funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
      is_mf     = (bus.funct == F_MFHI) || (bus.funct == F_MFLO);
      abs_a     = (is_signed_q && op_a_q[XLEN-1]) ? -op_a_q : op_a_q;
      abs_b     = (is_signed_q && op_b_q[XLEN-1]) ? -op_b_q : op_b_q;
      mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mcand_q : '0)};
      rem_sh    = {acc_hi_q, acc_lo_q[XLEN-1]};
      prod_fix  = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_div_d    = is_div_q;
      is_signed_d = is_signed_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      acc_hi_d    = acc_hi_q;
      acc_lo_d    = acc_lo_q;
      mcand_d     = mcand_q;
      neg_d       = neg_q;
      rem_neg_d   = rem_neg_q;
      dbz_path_d  = dbz_path_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      done_d      = 1'b0;
      dbz_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.op_valid && is_muldiv && !bus.flush) begin
               op_a_d      = bus.rs;
               op_b_d      = bus.rt;
               is_div_d    = bus.funct[1];
               is_signed_d = !bus.funct[0];
               state_d     = S_PREP;
            end
         end
         S_PREP: begin
            acc_hi_d   = '0;
            cnt_d      = '0;
            neg_d      = is_signed_q && (op_a_q[XLEN-1] ^ op_b_q[XLEN-1]);
            rem_neg_d  = is_signed_q && op_a_q[XLEN-1];
            dbz_path_d = is_div_q && (op_b_q == '0);
            if (is_div_q) begin
               acc_lo_d = abs_a;
               mcand_d  = abs_b;
            end else begin
               acc_lo_d = abs_b;
               mcand_d  = abs_a;
            end
            state_d = (is_div_q && (op_b_q == '0)) ? S_FIX : S_ITER;
         end
         S_ITER: begin
            // Divide shifts the dividend out of acc_lo while quotient bits shift in.
            if (is_div_q) begin
               if (rem_sh >= {1'b0, mcand_q}) begin
                  acc_hi_d = rem_sh[XLEN-1:0] - mcand_q;
                  acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
               end else begin
                  acc_hi_d = rem_sh[XLEN-1:0];
                  acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
               end
            end else begin
               acc_hi_d = mul_sum[XLEN:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (dbz_path_q) begin
               hi_d  = op_a_q;
               lo_d  = '1;
               dbz_d = 1'b1;
            end else if (is_div_q) begin
               lo_d = neg_q ? -acc_lo_q : acc_lo_q;
               hi_d = rem_neg_q ? -acc_hi_q : acc_hi_q;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // An abort discards the in-flight result entirely, including a pending FIX write.
      if (bus.flush && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
         dbz_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         is_div_q    <= 1'b0;
         is_signed_q <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         mcand_q     <= '0;
         neg_q       <= 1'b0;
         rem_neg_q   <= 1'b0;
         dbz_path_q  <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_div_q    <= is_div_d;
         is_signed_q <= is_signed_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         acc_hi_q    <= acc_hi_d;
         acc_lo_q    <= acc_lo_d;
         mcand_q     <= mcand_d;
         neg_q       <= neg_d;
         rem_neg_q   <= rem_neg_d;
         dbz_path_q  <= dbz_path_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         done_q      <= done_d;
         dbz_q       <= dbz_d;
      end
   end

   always_comb begin
      bus.busy        = (state_q != S_IDLE);
      bus.stall       = (state_q != S_IDLE) ||
                        (bus.op_valid && (is_muldiv || is_mf) && (state_q != S_IDLE));
      bus.done        = done_q;
      bus.div_by_zero = dbz_q;
      if (bus.funct == F_MFHI) begin
         bus.hilo_data = hi_q;
      end else if (bus.funct == F_MFLO) begin
         bus.hilo_data = lo_q;
      end else begin
         bus.hilo_data = '0;
      end
   end
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Scoreboard bench for ex_muldiv_sequencer: arithmetic reference model, done-driven monitor.
module tb_ex_muldiv_sequencer;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   typedef struct packed {
      logic        dbz;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [31:0] mdl_hi = '0;
   logic [31:0] mdl_lo = '0;

   always #5 clk = ~clk;

   ex_muldiv_sequencer_if #(.XLEN(32)) bus ();
   ex_muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      longint sa, sb, q, r;
      longint unsigned p;
      e  = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f)
         F_MULTU: begin p = {32'b0, a} * {32'b0, b}; {e.hi, e.lo} = p; end
         F_MULT:  begin q = sa * sb; {e.hi, e.lo} = q; end
         F_DIVU, F_DIV: begin
            if (b == 32'd0) begin
               e.dbz = 1'b1; e.hi = a; e.lo = 32'hFFFF_FFFF;
            end else if (f == F_DIVU) begin
               e.lo = a / b; e.hi = a % b;
            end else begin
               q = sa / sb; r = sa % sb;
               e.lo = q[31:0]; e.hi = r[31:0];
            end
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   // Monitor: pops an expectation on every done pulse, checks every unstalled HI/LO read.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            mdl_hi = '0;
            mdl_lo = '0;
         end else begin
            if (bus.done) begin
               check("done_has_pending_op", 64'(exp_q.size() > 0), 64'd1);
               if (exp_q.size() > 0) begin
                  mon_e = exp_q.pop_front();
                  check("div_by_zero_flag", 64'(bus.div_by_zero), 64'(mon_e.dbz));
                  mdl_hi = mon_e.hi;
                  mdl_lo = mon_e.lo;
               end
            end
            if (bus.div_by_zero) check("dbz_with_done", 64'(bus.done), 64'd1);
            if (bus.op_valid && !bus.stall && bus.funct == F_MFHI)
               check("mfhi_data", 64'(bus.hilo_data), 64'(mdl_hi));
            if (bus.op_valid && !bus.stall && bus.funct == F_MFLO)
               check("mflo_data", 64'(bus.hilo_data), 64'(mdl_lo));
         end
      end
   end

   task automatic wait_done(input string name, input int exp_idx);
      int idx, busy_cnt, stall_cnt;
      idx = -1; busy_cnt = 0; stall_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.done) begin idx = i; break; end
         if (bus.busy)  busy_cnt++;
         if (bus.stall) stall_cnt++;
      end
      check({name, "_done_latency"}, 64'(idx), 64'(exp_idx));
      check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_idx));
      check({name, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_idx));
      if (idx >= 0) check({name, "_stall_in_done"}, 64'(bus.stall), 64'd0);
   endtask

   // Presents the op for one cycle, then holds an MFHI behind it.
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
      @(posedge clk); #2;
      bus.op_valid = 1'b1; bus.funct = f; bus.rs = a; bus.rt = b;
      if (push) exp_q.push_back(model(f, a, b));
      @(posedge clk); #2;
      bus.funct = F_MFHI; bus.rs = $urandom; bus.rt = $urandom;
   endtask

   task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      issue(f, a, b, 1'b1);
      wait_done(name, ((f == F_DIV || f == F_DIVU) && b == 32'd0) ? 2 : 34);
      @(posedge clk); #2;
      bus.funct = F_MFLO;
      @(posedge clk); #2;
      bus.op_valid = 1'b0; bus.funct = 6'h00;
   endtask

   task automatic expect_quiet(input string name, input int cycles);
      int n;
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.done || bus.div_by_zero) n++;
      end
      check({name, "_no_done"}, 64'(n), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] ftab [4];
      logic [5:0] f;
      logic [31:0] a, b;
      ftab[0] = F_MULT; ftab[1] = F_MULTU; ftab[2] = F_DIV; ftab[3] = F_DIVU;

      reset = 1'b0; bus.op_valid = 1'b0; bus.flush = 1'b0;
      bus.funct = F_MFHI; bus.rs = '0; bus.rt = '0;
      #1;
      check("reset_busy",  64'(bus.busy),  64'd0);
      check("reset_stall", 64'(bus.stall), 64'd0);
      check("reset_done",  64'(bus.done),  64'd0);
      check("reset_dbz",   64'(bus.div_by_zero), 64'd0);
      check("reset_hilo",  64'(bus.hilo_data), 64'd0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1; bus.funct = 6'h00;

      run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mult_neg",  F_MULT,  32'hFFFF_FFFD, 32'd7);
      run_op("div_neg",   F_DIV,   32'hFFFF_FFF9, 32'd2);
      run_op("divu_small", F_DIVU, 32'd100, 32'd7);
      run_op("divu_zero", F_DIVU,  32'h0000_1234, 32'd0);
      run_op("div_ovf",   F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run_op("div_zero",  F_DIV,   32'h8765_4321, 32'd0);

      // Back-to-back: second MULT held by stall, accepted on the done edge.
      issue(F_MULT, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
      bus.funct = F_MULT; bus.rs = 32'h8000_0001; bus.rt = 32'h7FFF_FFFF;
      exp_q.push_back(model(F_MULT, 32'h8000_0001, 32'h7FFF_FFFF));
      wait_done("b2b_first", 34);
      @(posedge clk); #2;
      bus.funct = F_MFHI;
      wait_done("b2b_second", 34);
      @(posedge clk); #2 bus.funct = F_MFLO;
      @(posedge clk); #2 bus.op_valid = 1'b0; bus.funct = 6'h00;

      for (int i = 0; i < 12; i++) begin
         f = ftab[$urandom_range(0, 3)];
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
            2: b = {{28{b[31]}}, b[3:0]};
            default: ;
         endcase
         run_op("random_op", f, a, b);
      end

      // Flush mid-ITER: no done, HI/LO keep prior values (checked by held MFHI then MFLO).
      issue(F_MULTU, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
      repeat (10) @(posedge clk);
      #2 bus.flush = 1'b1;
      @(posedge clk); #2 bus.flush = 1'b0;
      @(negedge clk);
      check("flush_busy",  64'(bus.busy),  64'd0);
      check("flush_stall", 64'(bus.stall), 64'd0);
      @(posedge clk); #2 bus.funct = F_MFLO;
      @(posedge clk); #2 bus.op_valid = 1'b0; bus.funct = 6'h00;
      expect_quiet("flush_iter", 40);

      // Flush together with op_valid in IDLE: nothing accepted.
      @(posedge clk); #2;
      bus.op_valid = 1'b1; bus.funct = F_DIV; bus.rs = 32'd50; bus.rt = 32'd3; bus.flush = 1'b1;
      @(posedge clk); #2 bus.op_valid = 1'b0; bus.flush = 1'b0; bus.funct = 6'h00;
      @(negedge clk);
      check("flush_idle_busy", 64'(bus.busy), 64'd0);
      expect_quiet("flush_idle", 40);

      // Asynchronous reset mid-operation.
      issue(F_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      repeat (20) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("arst_busy",  64'(bus.busy),  64'd0);
      check("arst_stall", 64'(bus.stall), 64'd0);
      check("arst_done",  64'(bus.done),  64'd0);
      check("arst_dbz",   64'(bus.div_by_zero), 64'd0);
      check("arst_hi",    64'(bus.hilo_data), 64'd0);
      bus.funct = F_MFLO;
      #1 check("arst_lo", 64'(bus.hilo_data), 64'd0);
      @(posedge clk); #2 reset = 1'b1; bus.op_valid = 1'b0; bus.funct = 6'h00;
      expect_quiet("after_reset", 40);
      @(posedge clk); #2 bus.op_valid = 1'b1; bus.funct = F_MFHI;
      @(posedge clk); #2 bus.funct = F_MFLO;
      @(posedge clk); #2 bus.op_valid = 1'b0; bus.funct = 6'h00;

      run_op("post_reset_div", F_DIV, 32'hFFFF_FF00, 32'd16);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller beside the EX-stage ALU.
- Sequences 32-iteration shift-add multiply and restoring divide for R-type funct MULT/MULTU/DIV/DIVU.
- Owns the HI/LO registers and serves MFHI/MFLO reads.
- Raises stall to freeze IF/ID/EX while an operation is in flight.

Parameters:
- XLEN, 32, operand width; the iteration count equals XLEN.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  ID/EX holds a valid R-type instruction this cycle
- funct  in  6  instruction funct field from the decode unit
- rs  in  32  operand A (dividend / multiplicand)
- rt  in  32  operand B (divisor / multiplier)
- flush  in  1  pipeline flush; aborts the in-flight op
- busy  out  1  operation in progress
- stall  out  1  freeze pipeline registers upstream of EX
- done  out  1  one-cycle pulse when HI/LO are updated
- div_by_zero  out  1  one-cycle pulse, coincident with done, for DIV/DIVU with rt=0
- hilo_data  out  32  HI (funct 0x10) or LO (funct 0x12) read data

Behaviour:
- Decode: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x10 MFHI, 0x12 MFLO. Any other funct is ignored.
- Reset (reset=0, asynchronous): state=IDLE, HI=LO=0, counter=0; busy, stall, done and div_by_zero all 0; hilo_data=0.
- States: IDLE, PREP, ITER, FIX.
- IDLE: on op_valid and a mul/div funct, capture rs/rt/funct and go to PREP (accept edge k).
- PREP (1 cycle):
  - Signed ops: take magnitudes and record result signs.
  - Unsigned ops: pass operands through unchanged.
  - Divide with rt=0: go directly to FIX. Otherwise go to ITER with counter=0.
- ITER: one partial-product or partial-remainder step per cycle. After 32 steps (counter=31), go to FIX.
- FIX (1 cycle): apply sign correction, write HI/LO, pulse done, return to IDLE.
- Latency: HI/LO are written on edge k+34 and done is high in the following cycle. Divide-by-zero path writes on edge k+2.
- busy: high from edge k until edge k+34; low in the done cycle.
- Multiply: 64-bit product, {HI,LO}. MULT negates the 64-bit result when operand signs differ.
- Divide: LO=quotient, HI=remainder.
  - Quotient is negated if signs differ.
  - Remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0; no trap.
- Divide by zero: HI=rs, LO=0xFFFFFFFF, div_by_zero pulses with done.
- stall = busy OR (op_valid AND funct is a mul/div/MFHI/MFLO AND state is not IDLE).
  - New mul/div issued while busy is not accepted; the instruction is held by stall.
  - Stall drops in the done cycle; a held instruction is accepted on that edge.
- MFHI/MFLO: hilo_data is combinational from HI/LO, valid when stall=0. A read in the done cycle returns the new value.
- flush: in any non-IDLE state, returns to IDLE on the next edge. HI/LO are unchanged and no done pulse is produced.
- flush and op_valid in the same IDLE cycle: flush wins and nothing is accepted.
- Reset mid-operation: immediate IDLE, all registers cleared, no done.
- done and div_by_zero are never asserted outside the FIX-to-IDLE transition cycle.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done exactly one cycle after edge k+34; busy high 34 cycles.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21); then MFLO -> hilo_data=0xFFFFFFEB with stall=0.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=100 rt=7 -> LO=14, HI=2.
- DIVU rs=0x1234 rt=0 -> HI=0x1234, LO=0xFFFFFFFF; done and div_by_zero pulse together one cycle after edge k+2.
- MFHI presented at cycle k+5 of a MULT -> stall held high through edge k+34, drops in done cycle, hilo_data equals new HI. Back-to-back MULT held by stall is accepted on the done edge.
- Flush at ITER step 10 -> IDLE next edge, HI/LO keep prior values, no done. Reset=0 at step 20 -> all outputs 0 asynchronously, HI=LO=0.
